// File: rtl/wb_wavelet_pkg.sv
// wb_wavelet_pkg: register offsets, CTRL/STATUS bit positions and FIFO count width helper
`timescale 1ns/1ps
package wb_wavelet_pkg;
  localparam logic [1:0] OFF_CTRL = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_TX = 2'd2;
  localparam logic [1:0] OFF_RX = 2'd3;
  localparam int CTRL_EN = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH = 2;
  localparam int ST_TX_FULL = 16;
  localparam int ST_RX_EMPTY = 17;
  localparam int ST_TX_DROP = 18;
  localparam int ST_RX_OVF = 19;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/wb_wavelet_responder_if.sv
// wb_wavelet_responder_if: Wishbone classic slave bus (stb/cyc/we/sel/adr/dat_i in, ack/dat_o out)
`timescale 1ns/1ps
interface wb_wavelet_responder_if;
  logic wbs_stb_i;
  logic wbs_cyc_i;
  logic wbs_we_i;
  logic [3:0] wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport slave (input wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, output wbs_ack_o, wbs_dat_o);
  modport master (output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, input wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO (clk, rst_n, i_clr, i_push/i_din, i_pop/o_dout head, o_count/o_full/o_empty), push+pop legal when full
`timescale 1ns/1ps
module sync_fifo
  import wb_wavelet_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clr,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [WIDTH-1:0]          i_din,
  output logic [WIDTH-1:0]          o_dout,
  output logic [cnt_w(DEPTH)-1:0]   o_count,
  output logic                      o_full,
  output logic                      o_empty
);
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  assign o_full = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_pop = i_pop & !o_empty;
  assign w_push = i_push & (!o_full | w_pop);
  assign o_dout = r_mem[r_rd];
  assign o_count = r_count;
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_mem[r_wr] <= i_din;
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/wb_wavelet_responder.sv
// wb_wavelet_responder: Wishbone slave (wb bus) feeding TX FIFO samples to the wavelet core (sample_o/sample_valid_o) and capturing results (result_i/result_valid_i) into an RX FIFO, irq_o on RX data
`timescale 1ns/1ps
module wb_wavelet_responder
  import wb_wavelet_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int DATA_W = 8,
  parameter int RES_W = 8,
  parameter int DEPTH = 8,
  parameter int SAMPLE_GAP = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  wb_wavelet_responder_if.slave wb,
  output logic [DATA_W-1:0]     sample_o,
  output logic                  sample_valid_o,
  input  logic [RES_W-1:0]      result_i,
  input  logic                  result_valid_i,
  output logic                  irq_o
);
  localparam int CW = cnt_w(DEPTH);
  localparam int GW = $clog2(SAMPLE_GAP + 1);
  logic r_ack, r_en, r_irq_en, r_tx_drop, r_rx_ovf, r_sample_valid, r_irq;
  logic [31:0] r_dat;
  logic [GW-1:0] r_gap;
  logic [DATA_W-1:0] r_sample;
  logic [1:0] w_off;
  logic w_req, w_wr, w_ctrl_wr, w_st_wr, w_flush, w_tx_push, w_issue, w_rx_pop, w_rx_try, w_unused;
  logic [31:0] w_status, w_rdata;
  logic [DATA_W-1:0] w_tx_dout;
  logic [RES_W-1:0] w_rx_dout;
  logic [CW-1:0] w_tx_count, w_rx_count;
  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  assign w_off = wb.wbs_adr_i[3:2];
  assign w_req = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]) & !r_ack;
  assign w_wr = w_req & wb.wbs_we_i;
  assign w_ctrl_wr = w_wr & (w_off == OFF_CTRL) & wb.wbs_sel_i[0];
  assign w_st_wr = w_wr & (w_off == OFF_STATUS) & wb.wbs_sel_i[2];
  assign w_flush = w_ctrl_wr & wb.wbs_dat_i[CTRL_FLUSH];
  assign w_tx_push = w_wr & (w_off == OFF_TX) & wb.wbs_sel_i[0];
  assign w_issue = r_en & !w_tx_empty & (r_gap == '0) & !w_flush;
  assign w_rx_pop = w_req & !wb.wbs_we_i & (w_off == OFF_RX) & !w_rx_empty;
  assign w_rx_try = result_valid_i & r_en & !w_flush;
  assign w_unused = ^{wb.wbs_sel_i, wb.wbs_adr_i[1:0], wb.wbs_dat_i};
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_tx (
    .clk(wb_clk_i), .rst_n(wb_rst_n), .i_clr(w_flush),
    .i_push(w_tx_push & !w_tx_full), .i_pop(w_issue), .i_din(wb.wbs_dat_i[DATA_W-1:0]),
    .o_dout(w_tx_dout), .o_count(w_tx_count), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );
  sync_fifo #(.WIDTH(RES_W), .DEPTH(DEPTH)) u_rx (
    .clk(wb_clk_i), .rst_n(wb_rst_n), .i_clr(w_flush),
    .i_push(w_rx_try), .i_pop(w_rx_pop), .i_din(result_i),
    .o_dout(w_rx_dout), .o_count(w_rx_count), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );
  always_comb begin
    w_status = '0;
    w_status[7:0] = 8'(w_tx_count);
    w_status[15:8] = 8'(w_rx_count);
    w_status[ST_TX_FULL] = w_tx_full;
    w_status[ST_RX_EMPTY] = w_rx_empty;
    w_status[ST_TX_DROP] = r_tx_drop;
    w_status[ST_RX_OVF] = r_rx_ovf;
    w_rdata = wb.wbs_we_i ? '0 :
              w_off == OFF_CTRL ? {30'b0, r_irq_en, r_en} :
              w_off == OFF_STATUS ? w_status :
              (w_off == OFF_RX && !w_rx_empty) ? 32'(w_rx_dout) : '0;
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      r_en <= 1'b0;
      r_irq_en <= 1'b0;
      r_tx_drop <= 1'b0;
      r_rx_ovf <= 1'b0;
      r_gap <= '0;
      r_sample <= '0;
      r_sample_valid <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_req ? w_rdata : '0;
      if (w_ctrl_wr) r_en <= wb.wbs_dat_i[CTRL_EN];
      if (w_ctrl_wr) r_irq_en <= wb.wbs_dat_i[CTRL_IRQ_EN];
      r_tx_drop <= (r_tx_drop & !(w_st_wr & wb.wbs_dat_i[ST_TX_DROP])) | (w_tx_push & w_tx_full);
      r_rx_ovf <= (r_rx_ovf & !(w_st_wr & wb.wbs_dat_i[ST_RX_OVF])) | (w_rx_try & w_rx_full & !w_rx_pop);
      r_gap <= w_flush ? '0 : w_issue ? GW'(SAMPLE_GAP - 1) : (r_gap == '0) ? '0 : r_gap - GW'(1);
      r_sample_valid <= w_issue;
      if (w_issue) r_sample <= w_tx_dout;
      r_irq <= r_irq_en & !w_rx_empty;
    end
  end
  assign wb.wbs_ack_o = r_ack;
  assign wb.wbs_dat_o = r_dat;
  assign sample_o = r_sample;
  assign sample_valid_o = r_sample_valid;
  assign irq_o = r_irq;
endmodule
